// File: rtl/lsu_pkg.sv
// Shared types and op-decoding helpers for the load/store unit.
// LSU_HALFWORD_SIGNED_EN enables the LB/LH/LHU/SH codes; without it they decode as NONE.
package lsu_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LW   = 4'd1,
    LBU  = 4'd2,
    SW   = 4'd3,
    SB   = 4'd4,
    LB   = 4'd5,
    LH   = 4'd6,
    LHU  = 4'd7,
    SH   = 4'd8
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_t;

  // Map a raw op code onto the ops this build supports; anything else is a pass-through.
  function automatic lsu_op_t eff_op(input logic [3:0] op);
    case (op)
      LW, LBU, SW, SB: return lsu_op_t'(op);
`ifdef LSU_HALFWORD_SIGNED_EN
      LB, LH, LHU, SH: return lsu_op_t'(op);
`endif
      default:         return NONE;
    endcase
  endfunction

  function automatic logic is_load(input lsu_op_t op);
    return op inside {LW, LBU, LB, LH, LHU};
  endfunction

  function automatic logic is_store(input lsu_op_t op);
    return op inside {SW, SB, SH};
  endfunction

  function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] offset);
    return ((op inside {LW, SW}) && (offset != 2'b00)) ||
           ((op inside {LH, LHU, SH}) && offset[0]);
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load-data alignment: selects the addressed byte/halfword and extends it.
// Signed and halfword variants exist only under LSU_HALFWORD_SIGNED_EN.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  lsu_op_t     op,
  output logic [31:0] value
);

  logic [7:0] lane [4];
  logic [7:0] byte_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = lane[offset];

`ifdef LSU_HALFWORD_SIGNED_EN
  logic [15:0] half_sel;
  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
`endif

  always_comb begin
    value = rdata;
    case (op)
      LBU:     value = {24'b0, byte_sel};
`ifdef LSU_HALFWORD_SIGNED_EN
      LB:      value = {{24{byte_sel[7]}}, byte_sel};
      LH:      value = {{16{half_sel[15]}}, half_sel};
      LHU:     value = {16'b0, half_sel};
`endif
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: issues req/gnt/rvalid accesses with byte-lane steering and writes back loads.
// LSU_HALFWORD_SIGNED_EN adds LB/LH/LHU/SH support.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [3:0]                ex_op,
  input  logic [ADDR_WIDTH-1:0]     ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_gnt,
  input  logic                      dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      misalign,
  output logic [ADDR_WIDTH-1:0]     misalign_addr
);

  lsu_state_t                state_reg, state_next;
  lsu_op_t                   op_reg, op_next, op_in;
  logic [1:0]                off_reg, off_next;
  logic [REG_ADDR_WIDTH-1:0] rd_reg, rd_next;

  logic                      ex_ready_reg;
  logic                      req_reg, req_next;
  logic                      we_reg, we_next;
  logic [ADDR_WIDTH-1:0]     addr_reg, addr_next;
  logic [3:0]                be_reg, be_next;
  logic [DATA_WIDTH-1:0]     wdata_reg, wdata_next;
  logic                      wb_valid_reg, wb_valid_next;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_reg, wb_rd_next;
  logic [DATA_WIDTH-1:0]     wb_data_reg, wb_data_next;
  logic                      misalign_reg, misalign_next;
  logic [ADDR_WIDTH-1:0]     misalign_addr_reg, misalign_addr_next;

  logic [3:0]                be_in;
  logic [DATA_WIDTH-1:0]     wdata_in;
  logic [31:0]               load_value;

  assign op_in = eff_op(ex_op);

  // Store lane steering; loads always read the whole word and extract afterwards.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = ex_wdata;
    case (op_in)
      SB: begin
        be_in    = 4'b0001 << ex_addr[1:0];
        wdata_in = {4{ex_wdata[7:0]}};
      end
`ifdef LSU_HALFWORD_SIGNED_EN
      SH: begin
        be_in    = 4'b0011 << {ex_addr[1], 1'b0};
        wdata_in = {2{ex_wdata[15:0]}};
      end
`endif
      default: ;
    endcase
  end

  lsu_load_extract u_extract (
    .rdata  (dmem_rdata),
    .offset (off_reg),
    .op     (op_reg),
    .value  (load_value)
  );

  always_comb begin
    state_next         = state_reg;
    op_next            = op_reg;
    off_next           = off_reg;
    rd_next            = rd_reg;
    req_next           = req_reg;
    we_next            = we_reg;
    addr_next          = addr_reg;
    be_next            = be_reg;
    wdata_next         = wdata_reg;
    wb_valid_next      = 1'b0;
    wb_rd_next         = wb_rd_reg;
    wb_data_next       = wb_data_reg;
    misalign_next      = 1'b0;
    misalign_addr_next = misalign_addr_reg;

    case (state_reg)
      IDLE: begin
        if (ex_valid && ex_ready_reg) begin
          if (op_in == NONE) begin
            wb_valid_next = 1'b1;
            wb_data_next  = DATA_WIDTH'(ex_addr);
            wb_rd_next    = ex_rd;
          end else if (is_misaligned(op_in, ex_addr[1:0])) begin
            misalign_next      = 1'b1;
            misalign_addr_next = ex_addr;
          end else begin
            state_next = REQ;
            op_next    = op_in;
            off_next   = ex_addr[1:0];
            rd_next    = ex_rd;
            req_next   = 1'b1;
            we_next    = is_store(op_in);
            addr_next  = {ex_addr[ADDR_WIDTH-1:2], 2'b00};
            be_next    = be_in;
            wdata_next = wdata_in;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          req_next   = 1'b0;
          state_next = is_store(op_reg) ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_next    = IDLE;
          wb_valid_next = 1'b1;
          wb_data_next  = load_value;
          wb_rd_next    = rd_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      op_reg            <= NONE;
      off_reg           <= 2'b00;
      rd_reg            <= '0;
      ex_ready_reg      <= 1'b1;
      req_reg           <= 1'b0;
      we_reg            <= 1'b0;
      addr_reg          <= '0;
      be_reg            <= 4'b0000;
      wdata_reg         <= '0;
      wb_valid_reg      <= 1'b0;
      wb_rd_reg         <= '0;
      wb_data_reg       <= '0;
      misalign_reg      <= 1'b0;
      misalign_addr_reg <= '0;
    end else begin
      state_reg         <= state_next;
      op_reg            <= op_next;
      off_reg           <= off_next;
      rd_reg            <= rd_next;
      ex_ready_reg      <= (state_next == IDLE);
      req_reg           <= req_next;
      we_reg            <= we_next;
      addr_reg          <= addr_next;
      be_reg            <= be_next;
      wdata_reg         <= wdata_next;
      wb_valid_reg      <= wb_valid_next;
      wb_rd_reg         <= wb_rd_next;
      wb_data_reg       <= wb_data_next;
      misalign_reg      <= misalign_next;
      misalign_addr_reg <= misalign_addr_next;
    end
  end

  assign ex_ready      = ex_ready_reg;
  assign dmem_req      = req_reg;
  assign dmem_we       = we_reg;
  assign dmem_addr     = addr_reg;
  assign dmem_be       = be_reg;
  assign dmem_wdata    = wdata_reg;
  assign wb_valid      = wb_valid_reg;
  assign wb_rd         = wb_rd_reg;
  assign wb_data       = wb_data_reg;
  assign misalign      = misalign_reg;
  assign misalign_addr = misalign_addr_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed table-driven bench for load_store_unit plus hand-written multi-cycle sequences.
// Expected values for LB/LH/LHU/SH follow LSU_HALFWORD_SIGNED_EN.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int K_NONE = 0;
  localparam int K_MIS  = 1;
  localparam int K_ST   = 2;
  localparam int K_LD   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [3:0]  ex_op = 4'd0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0BAD_0BAD;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic [31:0] misalign_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .misalign_addr(misalign_addr)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          gd;
    int          rvd;
    logic [31:0] rdata;
    int          kind;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] wbd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input int gd, input int rvd,
                              input logic [31:0] rdata, input int kind, input logic [3:0] be,
                              input logic [31:0] maddr, input logic [31:0] mwdata,
                              input logic [31:0] wbd);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd; v.gd = gd; v.rvd = rvd;
    v.rdata = rdata; v.kind = kind; v.be = be; v.maddr = maddr; v.mwdata = mwdata; v.wbd = wbd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ex_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready_before_issue"}, 32'(ex_ready), 32'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd);
    ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    wait_ready(p);
    issue(v.op, v.addr, v.wdata, v.rd);
    if (v.kind == K_NONE) begin
      chk({p, "_wb_valid"}, 32'(wb_valid), 32'd1);
      chk({p, "_wb_data"}, wb_data, v.wbd);
      chk({p, "_wb_rd"}, 32'(wb_rd), 32'(v.rd));
      chk({p, "_no_misalign"}, 32'(misalign), 32'd0);
      chk({p, "_no_req"}, 32'(dmem_req), 32'd0);
    end else if (v.kind == K_MIS) begin
      chk({p, "_misalign"}, 32'(misalign), 32'd1);
      chk({p, "_misalign_addr"}, misalign_addr, v.addr);
      chk({p, "_no_wb"}, 32'(wb_valid), 32'd0);
      chk({p, "_no_req"}, 32'(dmem_req), 32'd0);
      @(negedge clk);
      chk({p, "_misalign_pulse_end"}, 32'(misalign), 32'd0);
      chk({p, "_misalign_addr_held"}, misalign_addr, v.addr);
      chk({p, "_no_req_later"}, 32'(dmem_req), 32'd0);
    end else begin
      chk({p, "_req"}, 32'(dmem_req), 32'd1);
      chk({p, "_we"}, 32'(dmem_we), (v.kind == K_ST) ? 32'd1 : 32'd0);
      chk({p, "_addr"}, dmem_addr, v.maddr);
      chk({p, "_busy"}, 32'(ex_ready), 32'd0);
      if (v.kind == K_ST) begin
        chk({p, "_be"}, 32'(dmem_be), 32'(v.be));
        chk({p, "_wdata"}, dmem_wdata, v.mwdata);
      end
      for (int i = 0; i < v.gd; i++) begin
        @(negedge clk);
        chk({p, "_req_held"}, 32'(dmem_req), 32'd1);
        chk({p, "_addr_held"}, dmem_addr, v.maddr);
        if (v.kind == K_ST) chk({p, "_wdata_held"}, dmem_wdata, v.mwdata);
      end
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk({p, "_req_cleared"}, 32'(dmem_req), 32'd0);
      chk({p, "_no_wb_after_gnt"}, 32'(wb_valid), 32'd0);
      if (v.kind == K_ST) begin
        chk({p, "_ready_after_gnt"}, 32'(ex_ready), 32'd1);
      end else begin
        chk({p, "_busy_wait"}, 32'(ex_ready), 32'd0);
        for (int i = 0; i < v.rvd; i++) begin
          // Execute stage offers a NONE op while busy; it must be ignored.
          ex_valid = 1'b1; ex_op = 4'(NONE); ex_addr = 32'h5A; ex_rd = 5'd1;
          @(negedge clk);
          chk({p, "_no_wb_waiting"}, 32'(wb_valid), 32'd0);
        end
        ex_valid = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
        chk({p, "_wb_valid"}, 32'(wb_valid), 32'd1);
        chk({p, "_wb_data"}, wb_data, v.wbd);
        chk({p, "_wb_rd"}, 32'(wb_rd), 32'(v.rd));
        chk({p, "_ready_after_rvalid"}, 32'(ex_ready), 32'd1);
        @(negedge clk);
        chk({p, "_wb_pulse_end"}, 32'(wb_valid), 32'd0);
      end
    end
  endtask

  initial begin
    vecs.push_back(mk(4'(SW),  32'h100, 32'hDEADBEEF, 5'd0,  2, 0, 32'h0,        K_ST,   4'b1111, 32'h100, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(4'(SB),  32'h103, 32'h000000A5, 5'd0,  0, 0, 32'h0,        K_ST,   4'b1000, 32'h100, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(4'(LBU), 32'h202, 32'h0,        5'd7,  0, 0, 32'h11C37744, K_LD,   4'b0000, 32'h200, 32'h0,        32'h000000C3));
    vecs.push_back(mk(4'(LW),  32'h206, 32'h0,        5'd3,  0, 0, 32'h0,        K_MIS,  4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(4'(LW),  32'h204, 32'h0,        5'd9,  1, 2, 32'h12345678, K_LD,   4'b0000, 32'h204, 32'h0,        32'h12345678));
    vecs.push_back(mk(4'(SB),  32'h101, 32'h1234567E, 5'd0,  1, 0, 32'h0,        K_ST,   4'b0010, 32'h100, 32'h7E7E7E7E, 32'h0));
    vecs.push_back(mk(4'(LBU), 32'h003, 32'h0,        5'd31, 0, 1, 32'h80FF0102, K_LD,   4'b0000, 32'h0,   32'h0,        32'h00000080));
    vecs.push_back(mk(4'(SW),  32'h10A, 32'h11111111, 5'd0,  0, 0, 32'h0,        K_MIS,  4'b0000, 32'h0,   32'h0,        32'h0));
    vecs.push_back(mk(4'(LW),  32'h000, 32'h0,        5'd0,  0, 0, 32'hCAFEF00D, K_LD,   4'b0000, 32'h0,   32'h0,        32'hCAFEF00D));
    vecs.push_back(mk(4'(NONE),32'h1234,32'h0,        5'd5,  0, 0, 32'h0,        K_NONE, 4'b0000, 32'h0,   32'h0,        32'h1234));
`ifdef LSU_HALFWORD_SIGNED_EN
    vecs.push_back(mk(4'(LH),  32'h302, 32'h0,        5'd4,  0, 0, 32'h80010000, K_LD,   4'b0000, 32'h300, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk(4'(LB),  32'h001, 32'h0,        5'd6,  0, 0, 32'h00008000, K_LD,   4'b0000, 32'h0,   32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(4'(LHU), 32'h302, 32'h0,        5'd8,  1, 0, 32'h9ABC0000, K_LD,   4'b0000, 32'h300, 32'h0,        32'h00009ABC));
    vecs.push_back(mk(4'(SH),  32'h302, 32'h0000BEEF, 5'd0,  0, 0, 32'h0,        K_ST,   4'b1100, 32'h300, 32'hBEEFBEEF, 32'h0));
    vecs.push_back(mk(4'(LH),  32'h301, 32'h0,        5'd4,  0, 0, 32'h0,        K_MIS,  4'b0000, 32'h0,   32'h0,        32'h0));
`else
    vecs.push_back(mk(4'(LH),  32'h302, 32'h0,        5'd4,  0, 0, 32'h0,        K_NONE, 4'b0000, 32'h0,   32'h0,        32'h302));
    vecs.push_back(mk(4'(SH),  32'h303, 32'h0000BEEF, 5'd2,  0, 0, 32'h0,        K_NONE, 4'b0000, 32'h0,   32'h0,        32'h303));
    vecs.push_back(mk(4'(LB),  32'h001, 32'h0,        5'd6,  0, 0, 32'h0,        K_NONE, 4'b0000, 32'h0,   32'h0,        32'h001));
    vecs.push_back(mk(4'hF,    32'h0F0, 32'h0,        5'd11, 0, 0, 32'h0,        K_NONE, 4'b0000, 32'h0,   32'h0,        32'h0F0));
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_misalign_addr", misalign_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back pass-through ops: one writeback per cycle, never stalling
    ex_valid = 1'b1; ex_op = 4'(NONE); ex_rd = 5'd12;
    for (int i = 1; i <= 3; i++) begin
      ex_addr = 32'(i);
      @(negedge clk);
      chk($sformatf("b2b_%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("b2b_%0d_wb_data", i), wb_data, 32'(i));
      chk($sformatf("b2b_%0d_ready", i), 32'(ex_ready), 32'd1);
    end
    ex_valid = 1'b0;
    @(negedge clk);
    chk("b2b_pulse_end", 32'(wb_valid), 32'd0);

    foreach (vecs[i]) begin
      run_vec(vecs[i], i);
      $display("vector %0d op=%0d addr=0x%08h done", i, vecs[i].op, vecs[i].addr);
    end

    // Reset while waiting for read data, then a late rvalid that must be ignored
    wait_ready("rstwait");
    issue(4'(LW), 32'h40, 32'h0, 5'd6);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rstwait_in_wait_busy", 32'(ex_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstwait_async_ready", 32'(ex_ready), 32'd1);
    chk("rstwait_async_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_0077;
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
    chk("rstwait_late_rvalid_no_wb", 32'(wb_valid), 32'd0);
    chk("rstwait_wb_data_reset", wb_data, 32'd0);
    chk("rstwait_ready", 32'(ex_ready), 32'd1);
    issue(4'(NONE), 32'h99, 32'h0, 5'd3);
    chk("rstwait_idle_wb_valid", 32'(wb_valid), 32'd1);
    chk("rstwait_idle_wb_data", wb_data, 32'h99);
    $display("reset-in-wait sequence done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
